// File: rtl/shared_list_queue.sv
// shared_list_queue: NUM_LISTS independent FIFOs built as linked lists over a
// shared pool of NUM_ELEMS nodes. Unused nodes are chained on a free list.
// Push and pop may fire in the same cycle, including on the same list.
// Optional feature macro: SHARED_LIST_ERR_EN adds sticky err_overflow and
// err_underflow outputs.

// Per-list head/tail/count bookkeeping; one instance per list.
module shared_list_queue_list #(
  parameter int PTR_WIDTH = 3,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_hit,   // push fires on this list
  input  logic                 pop_hit,    // pop fires on this list
  input  logic [PTR_WIDTH-1:0] new_node,   // node taken from free list
  input  logic [PTR_WIDTH-1:0] head_next,  // successor of the popped head
  output logic [PTR_WIDTH-1:0] head,
  output logic [PTR_WIDTH-1:0] tail,
  output logic [CNT_WIDTH-1:0] count
);
  logic [PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 single;

  assign single = (count_q == CNT_WIDTH'(1));

  // Next head/tail/count; a same-cycle push+pop on a one-entry list makes
  // the new node both head and tail.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_WIDTH'(push_hit) - CNT_WIDTH'(pop_hit);
    if (pop_hit)
      head_d = (push_hit && single) ? new_node : head_next;
    else if (push_hit && (count_q == '0))
      head_d = new_node;
    if (push_hit)
      tail_d = new_node;
  end

  // List state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
endmodule

module shared_list_queue #(
  parameter int NUM_ELEMS  = 8,
  parameter int NUM_LISTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
  parameter int LIST_WIDTH = $clog2(NUM_LISTS),
  parameter int CNT_WIDTH  = PTR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [LIST_WIDTH-1:0] push_list,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop_valid,
  input  logic [LIST_WIDTH-1:0] pop_list,
  output logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_data_valid,
  output logic [NUM_LISTS-1:0]  empty,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  total_count
`ifdef SHARED_LIST_ERR_EN
  ,
  output logic                  err_overflow,
  output logic                  err_underflow
`endif
);
  localparam logic [CNT_WIDTH-1:0] POOL_SIZE = CNT_WIDTH'(NUM_ELEMS);

  logic [PTR_WIDTH-1:0]  next_q [NUM_ELEMS];
  logic [PTR_WIDTH-1:0]  next_d [NUM_ELEMS];
  logic [DATA_WIDTH-1:0] data_mem_q [NUM_ELEMS];
  logic [PTR_WIDTH-1:0]  free_head_q, free_head_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  pop_dv_q, pop_dv_d;

  logic [PTR_WIDTH-1:0]  head_w  [NUM_LISTS];
  logic [PTR_WIDTH-1:0]  tail_w  [NUM_LISTS];
  logic [CNT_WIDTH-1:0]  count_w [NUM_LISTS];

  logic                  push_in_range, pop_in_range;
  logic                  pop_list_empty;
  logic                  push_fire, pop_fire, same_single;
  logic [PTR_WIDTH-1:0]  new_node, pop_head, head_next;

  // List ids beyond NUM_LISTS only exist when NUM_LISTS is not a power of two.
  if (NUM_LISTS == (1 << LIST_WIDTH)) begin : g_ids_full
    assign push_in_range = 1'b1;
    assign pop_in_range  = 1'b1;
  end else begin : g_ids_partial
    localparam logic [LIST_WIDTH:0] LIST_LIMIT = (LIST_WIDTH+1)'(NUM_LISTS);
    assign push_in_range = ({1'b0, push_list} < LIST_LIMIT);
    assign pop_in_range  = ({1'b0, pop_list}  < LIST_LIMIT);
  end

  assign full           = (total_q == POOL_SIZE);
  assign push_ready     = !full;
  assign pop_list_empty = pop_in_range ? empty[pop_list] : 1'b1;
  assign pop_ready      = !pop_list_empty;
  assign push_fire      = push_valid && push_ready && push_in_range;
  assign pop_fire       = pop_valid && pop_ready;

  assign new_node    = free_head_q;
  assign pop_head    = head_w[pop_list];
  assign head_next   = next_q[pop_head];
  assign same_single = push_fire && pop_fire && (push_list == pop_list) &&
                       (count_w[pop_list] == CNT_WIDTH'(1));

  for (genvar l = 0; l < NUM_LISTS; l++) begin : g_list
    shared_list_queue_list #(
      .PTR_WIDTH (PTR_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_list (
      .clk       (clk),
      .rst       (rst),
      .push_hit  (push_fire && (push_list == LIST_WIDTH'(l))),
      .pop_hit   (pop_fire && (pop_list == LIST_WIDTH'(l))),
      .new_node  (new_node),
      .head_next (head_next),
      .head      (head_w[l]),
      .tail      (tail_w[l]),
      .count     (count_w[l])
    );
    assign empty[l] = (count_w[l] == '0);
  end

  // Link updates, free-list recycling, pop data capture and pool occupancy.
  // A popped head goes to the front of the free list; when a push consumes
  // the old free head in the same cycle it links to that node's successor.
  always_comb begin
    next_d      = next_q;
    free_head_d = free_head_q;
    pop_data_d  = pop_data_q;
    pop_dv_d    = pop_fire;
    total_d     = total_q + CNT_WIDTH'(push_fire) - CNT_WIDTH'(pop_fire);
    // The old tail is the node being popped in the one-entry case: no link.
    if (push_fire && !empty[push_list] && !same_single)
      next_d[tail_w[push_list]] = new_node;
    if (pop_fire) begin
      pop_data_d       = data_mem_q[pop_head];
      next_d[pop_head] = push_fire ? next_q[new_node] : free_head_q;
      free_head_d      = pop_head;
    end else if (push_fire) begin
      free_head_d = next_q[new_node];
    end
  end

  // Pointer/control registers; reset chains every node onto the free list.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_ELEMS; j++)
        next_q[j] <= PTR_WIDTH'((j + 1) % NUM_ELEMS);
      free_head_q <= '0;
      total_q     <= '0;
      pop_data_q  <= '0;
      pop_dv_q    <= 1'b0;
    end else begin
      next_q      <= next_d;
      free_head_q <= free_head_d;
      total_q     <= total_d;
      pop_data_q  <= pop_data_d;
      pop_dv_q    <= pop_dv_d;
    end
  end

  // Payload storage; not reset, written at the allocated node.
  always_ff @(posedge clk) begin
    if (!rst && push_fire)
      data_mem_q[new_node] <= push_data;
  end

  assign pop_data       = pop_data_q;
  assign pop_data_valid = pop_dv_q;
  assign total_count    = total_q;

`ifdef SHARED_LIST_ERR_EN
  logic err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;

  // Sticky protocol-error flags.
  always_comb begin
    err_ovf_d = err_ovf_q | (push_valid & full);
    err_unf_d = err_unf_q | (pop_valid & pop_list_empty);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
`endif
endmodule

// File: tb/tb_shared_list_queue.sv
// Scoreboard bench for shared_list_queue: stimulus pushes expected pop data
// into a queue, a negedge monitor pops and compares whenever pop_data_valid.
module tb_shared_list_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_valid = 1'b0;
  logic [1:0] push_list = '0;
  logic [7:0] push_data = '0;
  logic       push_ready;
  logic       pop_valid = 1'b0;
  logic [1:0] pop_list = '0;
  logic       pop_ready;
  logic [7:0] pop_data;
  logic       pop_data_valid;
  logic [3:0] empty;
  logic       full;
  logic [3:0] total_count;
`ifdef SHARED_LIST_ERR_EN
  logic       err_overflow, err_underflow;
`endif

  shared_list_queue dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_list(push_list), .push_data(push_data),
    .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_list(pop_list), .pop_ready(pop_ready),
    .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .empty(empty), .full(full), .total_count(total_count)
`ifdef SHARED_LIST_ERR_EN
    , .err_overflow(err_overflow), .err_underflow(err_underflow)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mq [4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_total();
    return mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size();
  endfunction

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  // One clock of stimulus; entered and left 1 time unit after posedge.
  task automatic cyc(input logic pv, input logic [1:0] pl, input logic [7:0] pd,
                     input logic qv, input logic [1:0] ql);
    bit pf, qf;
    push_valid = pv; push_list = pl; push_data = pd;
    pop_valid = qv;  pop_list = ql;
    #1;
    chk("push_ready", push_ready, model_total() < 8);
    chk("pop_ready", pop_ready, mq[ql].size() != 0);
    pf = pv && (model_total() < 8);
    qf = qv && (mq[ql].size() != 0);
    if (qf) exp_q.push_back(mq[ql].pop_front());
    if (pf) mq[pl].push_back(pd);
    @(posedge clk); #1;
    push_valid = 1'b0; pop_valid = 1'b0;
    chk("total_count", total_count, model_total());
    chk("empty", empty, model_empty());
    chk("full", full, model_total() == 8);
  endtask

  // Monitor: every presented pop result must match the scoreboard head.
  always @(negedge clk) begin
    if (pop_data_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pop_unexpected: got %0h expected none", pop_data);
      end else begin
        chk("pop_data", pop_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] p, q, t;
    int base;
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 0);
    chk("rst_total", total_count, 0);
    chk("rst_pdv", pop_data_valid, 0);
    chk("rst_pdata", pop_data, 0);
    rst = 1'b0;
    #1;
    chk("rst_push_ready", push_ready, 1);

    // FIFO order on list 2, back-to-back pops
    cyc(1, 2, 8'h11, 0, 0);
    cyc(1, 2, 8'h22, 0, 0);
    cyc(1, 2, 8'h33, 0, 0);
    chk("l2_empty_bits", empty, 4'b1011);
    cyc(0, 0, 0, 1, 2);
    cyc(0, 0, 0, 1, 2);
    cyc(0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0);
    chk("pop_data_hold", pop_data, 8'h33);
    chk("pdv_idle", pop_data_valid, 0);

    // Fill pool alternating lists 0/1, then reuse a freed node
    for (int i = 0; i < 8; i++) cyc(1, 2'(i % 2), 8'(8'h40 + i), 0, 0);
    chk("fill_full", full, 1);
    chk("fill_push_ready", push_ready, 0);
    cyc(1, 2, 8'hEE, 0, 0);              // refused while full
    cyc(0, 0, 0, 1, 0);                  // 0x40
    chk("after_pop_full", full, 0);
    cyc(1, 2, 8'h99, 0, 0);
    cyc(0, 0, 0, 1, 2);                  // 0x99 from recycled node
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("drain_empty", empty, 4'hF);

    // Same-list push+pop on a one-entry list
    cyc(1, 3, 8'hAA, 0, 0);
    cyc(1, 3, 8'hBB, 1, 3);              // pops 0xAA
    chk("l3_one_left", empty[3], 0);
    cyc(0, 0, 0, 1, 3);                  // pops 0xBB
    cyc(0, 0, 0, 0, 0);

    // Simultaneous push/pop on different lists, total constant
    cyc(1, 0, 8'h01, 0, 0);
    cyc(1, 0, 8'h02, 0, 0);
    cyc(1, 1, 8'h03, 0, 0);
    cyc(1, 1, 8'h04, 0, 0);
    base = model_total();
    for (int i = 0; i < 20; i++) begin
      p = 2'($urandom_range(0, 1));
      q = 2'd1 - p;
      if (mq[q].size() == 0) begin t = p; p = q; q = t; end
      cyc(1, p, 8'($urandom), 1, q);
      chk("total_const", total_count, base);
    end
    cyc(0, 0, 0, 0, 0);

    // Reset mid-operation wins over fires
    push_valid = 1'b1; push_list = 0; push_data = 8'h77;
    pop_valid = 1'b1;  pop_list = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; push_valid = 1'b0; pop_valid = 1'b0;
    for (int i = 0; i < 4; i++) mq[i].delete();
    chk("mrst_empty", empty, 4'hF);
    chk("mrst_total", total_count, 0);
    chk("mrst_pdv", pop_data_valid, 0);
    cyc(1, 1, 8'h5A, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);

`ifdef SHARED_LIST_ERR_EN
    chk("err_unf_clear", err_underflow, 0);
    cyc(0, 0, 0, 1, 1);                  // pop on empty list 1
    chk("err_unf_set", err_underflow, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("err_unf_sticky", err_underflow, 1);
    chk("err_ovf_clear", err_overflow, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_unf_rst", err_underflow, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
